trp_wr_buf: RTL and testbench

TRP_WR_BUF -- requirements
Module: trp_wr_buf

---
 rtl/trp_wr_buf.sv | 148 ++++++++++++++
 tb/tb_trp_wr_buf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trp_wr_buf.sv
// Write buffer between the transpose stage and memory: a FIFO of {addr, data}
// entries drained under mem_wrdy, with job tracking (expected write count, done pulse).
module trp_wr_buf #(
  parameter int AW    = 16,
  parameter int BUFFD = 64,
  parameter int FD    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_pulse,
  input  logic [AW-1:0]         wr_total,
  input  logic [AW-1:0]         waddr,
  input  logic [BUFFD*8-1:0]    wdata,
  input  logic                  wdata_vld,
  output logic [AW-1:0]         mem_waddr,
  output logic [BUFFD*8-1:0]    mem_wdata,
  output logic                  mem_wvld,
  input  logic                  mem_wrdy,
  output logic [$clog2(FD):0]   level,
  output logic                  ovf,
  output logic                  err_unexp,
  output logic                  done
);

  localparam int DW = BUFFD * 8;
  localparam int PW = $clog2(FD);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] total_q, total_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          push;
  logic          pop;
  logic          store;
  logic          full;

  entry_t        mem_q [FD];
  entry_t        head;

  assign full = (level_q == LW'(FD));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    store    = 1'b0;

    if (init_pulse) begin
      // A new job wins over everything else in this cycle, including a write or a pop.
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      total_d  = wr_total;
      state_d  = (wr_total == '0) ? ST_DRAIN : ST_RUN;
    end else begin
      pop   = (level_q != '0) && mem_wrdy;
      push  = wdata_vld && (state_q == ST_RUN);
      store = push && (!full || pop);

      if (wdata_vld && (state_q != ST_RUN)) err_d = 1'b1;
      if (push && !store)                   ovf_d = 1'b1;
      if (push)  cnt_d    = cnt_q + AW'(1);
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

      case ({store, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      // Pushes only happen in ST_RUN, so in ST_DRAIN an empty FIFO means nothing is pending.
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   if (push && (cnt_d == total_q)) state_d = ST_DRAIN;
        ST_DRAIN: if (level_q == '0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      total_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      total_q  <= total_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // NOTE: storage is not reset; the head outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && store) mem_q[wr_ptr_q] <= '{addr: waddr, data: wdata};
  end

  assign head      = mem_q[rd_ptr_q];
  assign mem_wvld  = (level_q != '0);
  assign mem_waddr = mem_wvld ? head.addr : '0;
  assign mem_wdata = mem_wvld ? head.data : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign err_unexp = err_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_trp_wr_buf.sv
// Bench for trp_wr_buf: directed vector table, hand-written corner sequences and
// randomized traffic, all compared every cycle against a queue-based job model.
module tb_trp_wr_buf;

  localparam int AW    = 16;
  localparam int BUFFD = 64;
  localparam int FD    = 8;
  localparam int DW    = BUFFD * 8;
  localparam int LW    = $clog2(FD) + 1;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk;
  logic          reset;
  logic          init_pulse;
  logic [AW-1:0] wr_total;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wdata_vld;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wvld;
  logic          mem_wrdy;
  logic [LW-1:0] level;
  logic          ovf;
  logic          err_unexp;
  logic          done;

  trp_wr_buf #(.AW(AW), .BUFFD(BUFFD), .FD(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_pulse (init_pulse),
    .wr_total   (wr_total),
    .waddr      (waddr),
    .wdata      (wdata),
    .wdata_vld  (wdata_vld),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wvld   (mem_wvld),
    .mem_wrdy   (mem_wrdy),
    .level      (level),
    .ovf        (ovf),
    .err_unexp  (err_unexp),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Job model: a plain queue of pending memory writes plus job bookkeeping.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   m_phase = P_IDLE;
  int   m_cnt   = 0;
  int   m_total = 0;
  bit   m_ovf   = 1'b0;
  bit   m_err   = 1'b0;

  function automatic void model_step(input bit rst, input bit init, input int tot, input bit vld,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rdy);
    int  pre;
    int  nxt;
    bit  pop;
    if (rst) begin
      q.delete();
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_total = 0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
    end else if (init) begin
      q.delete();
      m_cnt   = 0;
      m_total = tot;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
      m_phase = (tot == 0) ? P_DRAIN : P_RUN;
    end else begin
      pre = q.size();
      nxt = m_phase;
      pop = (pre > 0) && rdy;
      if (m_phase == P_DRAIN && pre == 0) nxt = P_DONE;
      else if (m_phase == P_DONE) nxt = P_IDLE;
      if (pop) void'(q.pop_front());
      if (vld) begin
        if (m_phase == P_RUN) begin
          m_cnt++;
          if (pre < FD || pop) q.push_back('{a: a, d: d});
          else m_ovf = 1'b1;
          if (m_cnt == m_total) nxt = P_DRAIN;
        end else begin
          m_err = 1'b1;
        end
      end
      m_phase = nxt;
    end
  endfunction

  task automatic compare_model();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ea = '0;
    ed = '0;
    if (q.size() > 0) begin
      ea = q[0].a;
      ed = q[0].d;
    end
    check("level",     DW'(level),     DW'(q.size()));
    check("mem_wvld",  DW'(mem_wvld),  DW'(q.size() > 0));
    check("mem_waddr", DW'(mem_waddr), DW'(ea));
    check("mem_wdata", mem_wdata,      ed);
    check("ovf",       DW'(ovf),       DW'(m_ovf));
    check("err_unexp", DW'(err_unexp), DW'(m_err));
    check("done",      DW'(done),      DW'(m_phase == P_DONE));
  endtask

  // One clock: drive inputs, advance the model, then sample #1 after the edge.
  task automatic tick(input bit rst, input bit init, input int tot, input bit vld,
                      input int a, input bit rdy);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    reset      = rst;
    init_pulse = init;
    wr_total   = AW'(tot);
    wdata_vld  = vld;
    waddr      = AW'(a);
    wdata      = d;
    mem_wrdy   = rdy;
    model_step(rst, init, tot, vld, AW'(a), d, rdy);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit            init;
    int            tot;
    bit            vld;
    int            addr;
    bit            rdy;
    int            e_level;
    bit            e_wvld;
    int            e_addr;
    bit            e_done;
    bit            e_ovf;
    bit            e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int pops;
    int dones;
    int rdy_pct;

    reset      = 1'b1;
    init_pulse = 1'b0;
    wr_total   = '0;
    waddr      = '0;
    wdata      = '0;
    wdata_vld  = 1'b0;
    mem_wrdy   = 1'b0;

    // Reset state, also with init_pulse held to show reset has priority.
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 5, 0, 0, 1);
    check("rst_level", DW'(level), DW'(0));
    check("rst_addr",  DW'(mem_waddr), DW'(0));
    check("rst_data",  mem_wdata, DW'(0));

    //              init tot vld addr  rdy | lvl wvld addr  done ovf err
    vecs.push_back('{1, 4, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 1, 'h10,  1,  1, 1, 'h10,  0, 0, 0});
    vecs.push_back('{0, 0, 1, 'h11,  1,  1, 1, 'h11,  0, 0, 0});
    vecs.push_back('{0, 0, 1, 'h12,  1,  1, 1, 'h12,  0, 0, 0});
    vecs.push_back('{0, 0, 1, 'h13,  1,  1, 1, 'h13,  0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{1, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 1, 'h55,  1,  0, 0, 0,     0, 0, 1});
    vecs.push_back('{1, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,     1,  0, 0, 0,     0, 0, 0});

    foreach (vecs[i]) begin
      tick(0, vecs[i].init, vecs[i].tot, vecs[i].vld, vecs[i].addr, vecs[i].rdy);
      check($sformatf("vec%0d_level", i), DW'(level),     DW'(vecs[i].e_level));
      check($sformatf("vec%0d_wvld", i),  DW'(mem_wvld),  DW'(vecs[i].e_wvld));
      check($sformatf("vec%0d_addr", i),  DW'(mem_waddr), DW'(vecs[i].e_addr));
      check($sformatf("vec%0d_done", i),  DW'(done),      DW'(vecs[i].e_done));
      check($sformatf("vec%0d_ovf", i),   DW'(ovf),       DW'(vecs[i].e_ovf));
      check($sformatf("vec%0d_err", i),   DW'(err_unexp), DW'(vecs[i].e_err));
    end

    // Saturation: 10 writes with memory stalled, 8 kept and 2 dropped, then drain.
    tick(0, 1, 10, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1, 'h100 + i, 0);
      if (i == 7) begin
        check("sat_level8", DW'(level), DW'(8));
        check("sat_ovf0",   DW'(ovf),   DW'(0));
      end
      if (i == 8) check("sat_ovf1", DW'(ovf), DW'(1));
    end
    check("sat_level_hold", DW'(level), DW'(8));
    pops  = 0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_wvld) begin
        check("sat_order", DW'(mem_waddr), DW'('h100 + pops));
        pops++;
      end
      tick(0, 0, 0, 0, 0, 1);
      if (done) dones++;
    end
    check("sat_pops",  DW'(pops),  DW'(8));
    check("sat_dones", DW'(dones), DW'(1));
    check("sat_ovf_sticky", DW'(ovf), DW'(1));

    // Full FIFO with a same-cycle pop accepts the write.
    tick(0, 1, 20, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 'h200 + i, 0);
    check("full_level", DW'(level), DW'(8));
    tick(0, 0, 0, 1, 'h208, 1);
    check("full_pop_level", DW'(level),     DW'(8));
    check("full_pop_ovf",   DW'(ovf),       DW'(0));
    check("full_pop_head",  DW'(mem_waddr), DW'('h201));

    // Mid-job reset at level 5, then a clean job.
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1);
    check("mid_level5", DW'(level), DW'(5));
    tick(1, 0, 0, 0, 0, 1);
    check("mid_rst_level", DW'(level),    DW'(0));
    check("mid_rst_wvld",  DW'(mem_wvld), DW'(0));
    tick(0, 0, 0, 0, 0, 1);
    check("mid_rst_quiet", DW'(mem_wvld), DW'(0));
    tick(0, 1, 3, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 'h300 + i, 1);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick(0, 0, 0, 0, 0, 1);
      if (done) dones++;
    end
    check("after_rst_dones", DW'(dones), DW'(1));

    // Randomized jobs, restarts and resets.
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      int r;
      bit rst;
      bit init;
      r    = $urandom_range(0, 999);
      rst  = (r < 3);
      init = (r >= 3 && r < 13) || (m_phase == P_IDLE && $urandom_range(0, 3) == 0);
      if (init) rdy_pct = $urandom_range(10, 100);
      tick(rst, init, $urandom_range(0, 14), $urandom_range(0, 99) < 70,
           $urandom_range(0, 'hffff), $urandom_range(1, 100) <= rdy_pct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
